freq_gate_controller: RTL and testbench
=======================================

Name: freq_gate_controller

Overview:
- Sequences one frequency-counter measurement: opens a gate window of a programmable number of reference-clock cycles and counts synchronized rising edges of an asynchronous input during the window.
- Latches the result and offers it to the display side over a valid/ready handshake.
- Sits between the 10 MHz reference clock domain and the OLED formatting/SPI path of the frequency counter.

Parameters:
- GATE_CYCLES, 10000000, gate length for gate_sel_in=0 (1 s at 10 MHz).
- COUNT_W, 32, edge-counter and result width.
- SYNC_STAGES, 2, synchronizer flops on clk_x_in (minimum 2).

Ports:
- clk_ref_in  input  1  reference clock; all logic on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  run measurements continuously while high.
- gate_sel_in  input  2  gate length select: 0=GATE_CYCLES, 1=/10, 2=/100, 3=/1000.
- clk_x_in  input  1  unknown-frequency signal, asynchronous to clk_ref_in.
- ready_in  input  1  consumer accepts the result.
- count_out  output  COUNT_W  edges counted in the last completed gate.
- range_out  output  2  gate_sel value used for count_out.
- overflow_out  output  1  count saturated during that gate.
- valid_out  output  1  result available.
- gate_out  output  1  high during the gate window (debug/LED).
- busy_out  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous, takes effect immediately with no clock edge required.
  - State goes to IDLE; the synchronizer chain and previous-sample flop clear to 0.
  - count_out=0, range_out=0, overflow_out=0, valid_out=0, gate_out=0, busy_out=0.
- Gate lengths: GATE_CYCLES/1, /10, /100, /1000 by integer division at elaboration, clamped to a minimum of 1.
- Edge detect:
  - clk_x_in passes through SYNC_STAGES flops, then one previous-sample flop.
  - pulse = sync & ~prev.
  - Maximum measurable frequency is below f(clk_ref_in)/2.
- FSM states: IDLE, ARM, GATE, PRESENT.
  - IDLE: if enable_in=1, go to ARM.
  - ARM (1 cycle): latch gate_sel_in; clear the edge counter and the saturate flag; load the gate timer with length-1; go to GATE.
  - GATE: gate_out=1.
    - Each cycle in GATE, a pulse increments the edge counter.
    - The counter saturates at all-ones; an increment attempted at all-ones sets the saturate flag.
    - The timer decrements each cycle. When it reads 0, go to PRESENT, so GATE lasts exactly <length> cycles.
    - If enable_in=0 during GATE, go to IDLE next cycle and discard the result; count_out and valid_out are unchanged.
  - PRESENT: on entry, count_out, range_out and overflow_out load together and valid_out=1.
    - Outputs hold stable while valid_out=1 and ready_in=0.
    - On valid_out & ready_in: valid_out goes to 0 next cycle. Go to ARM if enable_in=1, else IDLE.
    - enable_in=0 in PRESENT does not drop valid_out.
- Timing and latency:
  - enable_in first sampled high at edge 0 gives ARM after edge 0 and GATE for edges 1..L.
  - valid_out is high after edge L+1.
  - Back-to-back period is L+2 cycles plus handshake wait. No edges are counted outside GATE.
- Input changes: gate_sel_in changes outside ARM are ignored for the running measurement.
- Output retention: count_out, range_out and overflow_out retain the last accepted value after valid_out drops, until the next PRESENT entry.
- Simultaneous events:
  - A pulse on the final GATE cycle is counted.
  - Abort and the final GATE cycle in the same cycle: abort wins.

Test Plan:
- Common setup: GATE_CYCLES=1000, clk_ref_in 10 MHz, ready_in=1 unless stated.
- Basic count: clk_x_in 1 MHz, gate_sel_in=0, enable_in pulsed high → gate_out high exactly 1000 cycles; valid_out with count_out=100±1, range_out=0, overflow_out=0.
- Short gate: gate_sel_in=1, clk_x_in 1 MHz → gate_out high 100 cycles; count_out=10±1, range_out=1. Toggling gate_sel_in mid-gate does not change the gate length.
- Overflow: COUNT_W=4, clk_x_in 2.5 MHz, gate_sel_in=0 → count_out=15, overflow_out=1. The next measurement with clk_x_in static gives count_out=0, overflow_out=0.
- Backpressure: ready_in low for 50 cycles after valid_out → valid_out and count_out stable, gate_out=0 throughout. ready_in high → ARM next cycle, gate_out rises one cycle later.
- Abort: enable_in low at GATE cycle 500 → gate_out falls one cycle later, no valid_out, busy_out=0, count_out unchanged. Re-enable → fresh count_out=100±1.
- Async reset: reset_in asserted mid-GATE between clock edges → all outputs 0 before the next clk_ref_in edge. After release with enable_in high and clk_x_in static → count_out=0.

Source files
------------

// File: rtl/freq_gate_controller.sv
// freq_gate_controller: one gated frequency measurement at a time.
// Opens a gate window of a selectable number of reference cycles, counts
// synchronized rising edges of an asynchronous input during the window,
// then holds the result for the display side over a valid/ready handshake.
module freq_gate_controller #(
  parameter int GATE_CYCLES = 10000000,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_ref_in,
  input  logic               reset_in,
  input  logic               enable_in,
  input  logic [1:0]         gate_sel_in,
  input  logic               clk_x_in,
  input  logic               ready_in,
  output logic [COUNT_W-1:0] count_out,
  output logic [1:0]         range_out,
  output logic               overflow_out,
  output logic               valid_out,
  output logic               gate_out,
  output logic               busy_out
);

  // Gate lengths for each range, never shorter than one cycle.
  localparam int LEN0 = (GATE_CYCLES        >= 1) ? GATE_CYCLES        : 1;
  localparam int LEN1 = (GATE_CYCLES / 10   >= 1) ? GATE_CYCLES / 10   : 1;
  localparam int LEN2 = (GATE_CYCLES / 100  >= 1) ? GATE_CYCLES / 100  : 1;
  localparam int LEN3 = (GATE_CYCLES / 1000 >= 1) ? GATE_CYCLES / 1000 : 1;

  // Timer holds length-1 of the longest gate.
  localparam int TIMER_W = (LEN0 > 1) ? $clog2(LEN0) : 1;

  localparam logic [TIMER_W-1:0] LOAD0 = TIMER_W'(LEN0 - 1);
  localparam logic [TIMER_W-1:0] LOAD1 = TIMER_W'(LEN1 - 1);
  localparam logic [TIMER_W-1:0] LOAD2 = TIMER_W'(LEN2 - 1);
  localparam logic [TIMER_W-1:0] LOAD3 = TIMER_W'(LEN3 - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    GATE    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t               state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 prev_r;
  logic                 pulse_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [COUNT_W-1:0]   cnt_r;
  logic                 sat_r;
  logic [1:0]           sel_r;
  logic [COUNT_W-1:0]   cnt_next_s;
  logic                 sat_next_s;

  // Timer reload value (length-1) for a gate select code.
  function automatic logic [TIMER_W-1:0] gate_load(input logic [1:0] sel);
    case (sel)
      2'd0:    return LOAD0;
      2'd1:    return LOAD1;
      2'd2:    return LOAD2;
      2'd3:    return LOAD3;
      default: return LOAD0;
    endcase
  endfunction

  // Bring clk_x_in into the reference domain and keep one previous sample.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], clk_x_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign pulse_s = sync_r[SYNC_STAGES-1] & ~prev_r;

  // Saturating edge count including this cycle's pulse.
  always_comb begin
    cnt_next_s = cnt_r;
    sat_next_s = sat_r;
    if (pulse_s) begin
      if (&cnt_r) begin
        sat_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + COUNT_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
      sat_next_s = sat_r;
    end
  end

  // Measurement sequencer with registered status and result outputs.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      state_r      <= IDLE;
      timer_r      <= '0;
      cnt_r        <= '0;
      sat_r        <= 1'b0;
      sel_r        <= 2'd0;
      count_out    <= '0;
      range_out    <= 2'd0;
      overflow_out <= 1'b0;
      valid_out    <= 1'b0;
      gate_out     <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable_in) begin
            state_r  <= ARM;
            busy_out <= 1'b1;
          end
        end
        ARM: begin
          sel_r    <= gate_sel_in;
          cnt_r    <= '0;
          sat_r    <= 1'b0;
          timer_r  <= gate_load(gate_sel_in);
          gate_out <= 1'b1;
          state_r  <= GATE;
        end
        GATE: begin
          if (!enable_in) begin
            // Abort: result is discarded, previous output stays visible.
            state_r  <= IDLE;
            gate_out <= 1'b0;
            busy_out <= 1'b0;
          end else if (timer_r == '0) begin
            // Last gate cycle: its pulse is included in the result.
            state_r      <= PRESENT;
            gate_out     <= 1'b0;
            cnt_r        <= cnt_next_s;
            sat_r        <= sat_next_s;
            count_out    <= cnt_next_s;
            overflow_out <= sat_next_s;
            range_out    <= sel_r;
            valid_out    <= 1'b1;
          end else begin
            cnt_r   <= cnt_next_s;
            sat_r   <= sat_next_s;
            timer_r <= timer_r - TIMER_W'(1);
          end
        end
        PRESENT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            if (enable_in) begin
              state_r <= ARM;
            end else begin
              state_r  <= IDLE;
              busy_out <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          gate_out  <= 1'b0;
          busy_out  <= 1'b0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller: a 32-bit instance for the
// counting/handshake/abort/reset scenarios and a 4-bit instance for overflow.
`timescale 1ns/1ps
module tb_freq_gate_controller;

  localparam int GC = 1000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready;
  logic [1:0]  sel;
  logic        x_raw;
  logic        x_run;
  logic        x;
  logic [31:0] count;
  logic [1:0]  range;
  logic        ovf;
  logic        valid;
  logic        gate;
  logic        busy;

  logic        en2;
  logic        ready2;
  logic [1:0]  sel2;
  logic        xf_raw;
  logic        x2_run;
  logic        x2;
  logic [3:0]  count2;
  logic [1:0]  range2;
  logic        ovf2;
  logic        valid2;
  logic        gate2;
  logic        busy2;

  int checks;
  int failures;

  assign x  = x_raw & x_run;
  assign x2 = xf_raw & x2_run;

  freq_gate_controller #(.GATE_CYCLES(GC), .COUNT_W(32), .SYNC_STAGES(2)) u_dut (
    .clk_ref_in(clk), .reset_in(rst), .enable_in(en), .gate_sel_in(sel),
    .clk_x_in(x), .ready_in(ready), .count_out(count), .range_out(range),
    .overflow_out(ovf), .valid_out(valid), .gate_out(gate), .busy_out(busy)
  );

  freq_gate_controller #(.GATE_CYCLES(GC), .COUNT_W(4), .SYNC_STAGES(2)) u_ovf (
    .clk_ref_in(clk), .reset_in(rst), .enable_in(en2), .gate_sel_in(sel2),
    .clk_x_in(x2), .ready_in(ready2), .count_out(count2), .range_out(range2),
    .overflow_out(ovf2), .valid_out(valid2), .gate_out(gate2), .busy_out(busy2)
  );

  // 10 MHz reference clock.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // 1 MHz unknown input, phase kept away from reference edges.
  initial begin
    x_raw = 1'b0;
    #37;
    forever #500 x_raw = ~x_raw;
  end

  // 2.5 MHz unknown input for the overflow instance.
  initial begin
    xf_raw = 1'b0;
    #13;
    forever #200 xf_raw = ~xf_raw;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Count gate_out-high cycles until valid_out rises, bounded.
  task automatic run_meas(output int glen, output bit ok);
    glen = 0;
    ok   = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (gate === 1'b1) glen++;
      if (valid === 1'b1) ok = 1'b1;
    end
  endtask

  int gl;
  bit ok;
  int bad;
  int n;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; ready = 1'b0; sel = 2'd0; x_run = 1'b1;
    en2 = 1'b0; ready2 = 1'b0; sel2 = 2'd0; x2_run = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_count", count, 32'd0);
    check_eq("rst_range", {30'd0, range}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_gate", {31'd0, gate}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst2_state", {28'd0, valid2, gate2, busy2, ovf2}, 32'd0);
    check_eq("rst2_count", {28'd0, count2}, 32'd0);
    rst = 1'b0;

    // Basic count: 1 MHz over 1000 cycles
    @(negedge clk);
    en = 1'b1;
    run_meas(gl, ok);
    check_eq("basic_valid", {31'd0, ok}, 32'd1);
    check_eq("basic_glen", gl, 32'd1000);
    check_eq("basic_count", count, 32'd100);
    check_eq("basic_range", {30'd0, range}, 32'd0);
    check_eq("basic_ovf", {31'd0, ovf}, 32'd0);
    check_eq("basic_busy", {31'd0, busy}, 32'd1);

    // Backpressure: outputs hold for 50 cycles
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid !== 1'b1 || count !== 32'd100 || gate !== 1'b0) bad++;
    end
    check_eq("bp_stable", bad, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    check_eq("bp_valid_drop", {31'd0, valid}, 32'd0);
    check_eq("bp_arm_busy", {31'd0, busy}, 32'd1);
    check_eq("bp_arm_gate", {31'd0, gate}, 32'd0);
    check_eq("bp_retain", count, 32'd100);
    ready = 1'b0;
    @(negedge clk);
    check_eq("bp_gate_rise", {31'd0, gate}, 32'd1);

    // gate_sel changes mid-gate do not alter the running gate
    sel = 2'd3;
    run_meas(gl, ok);
    check_eq("midsel_valid", {31'd0, ok}, 32'd1);
    check_eq("midsel_glen", gl, 32'd999);
    check_eq("midsel_count", count, 32'd100);
    check_eq("midsel_range", {30'd0, range}, 32'd0);

    // Short gate: /10
    sel = 2'd1;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    run_meas(gl, ok);
    check_eq("short_valid", {31'd0, ok}, 32'd1);
    check_eq("short_glen", gl, 32'd100);
    check_eq("short_count", count, 32'd10);
    check_eq("short_range", {30'd0, range}, 32'd1);

    // Abort at gate cycle 500
    sel = 2'd0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && n < 500; i++) begin
      @(negedge clk);
      if (gate === 1'b1) n++;
    end
    check_eq("abort_reach", n, 32'd500);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort_gate", {31'd0, gate}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_valid", {31'd0, valid}, 32'd0);
    check_eq("abort_count", count, 32'd10);
    check_eq("abort_range", {30'd0, range}, 32'd1);
    repeat (20) @(negedge clk);
    check_eq("abort_valid_late", {31'd0, valid}, 32'd0);

    // Re-enable gives a fresh measurement
    en = 1'b1;
    run_meas(gl, ok);
    check_eq("reen_valid", {31'd0, ok}, 32'd1);
    check_eq("reen_glen", gl, 32'd1000);
    check_eq("reen_count", count, 32'd100);
    check_eq("reen_range", {30'd0, range}, 32'd0);

    // Async reset between edges mid-gate
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("ar_in_gate", {31'd0, gate}, 32'd1);
    #25;
    rst = 1'b1;
    x_run = 1'b0;
    #1;
    check_eq("ar_count", count, 32'd0);
    check_eq("ar_flags", {27'd0, range, ovf, valid, gate}, 32'd0);
    check_eq("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_meas(gl, ok);
    check_eq("ar_post_valid", {31'd0, ok}, 32'd1);
    check_eq("ar_post_glen", gl, 32'd1000);
    check_eq("ar_post_count", count, 32'd0);
    check_eq("ar_post_ovf", {31'd0, ovf}, 32'd0);
    en = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // Overflow: 2.5 MHz into a 4-bit counter
    en2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (valid2 === 1'b1) ok = 1'b1;
    end
    check_eq("ovf_valid", {31'd0, ok}, 32'd1);
    check_eq("ovf_count", {28'd0, count2}, 32'd15);
    check_eq("ovf_flag", {31'd0, ovf2}, 32'd1);
    check_eq("ovf_range", {30'd0, range2}, 32'd0);

    // Next measurement with the input held static
    x2_run = 1'b0;
    repeat (5) @(negedge clk);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (valid2 === 1'b1) ok = 1'b1;
    end
    check_eq("static_valid", {31'd0, ok}, 32'd1);
    check_eq("static_count", {28'd0, count2}, 32'd0);
    check_eq("static_ovf", {31'd0, ovf2}, 32'd0);
    en2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
